// File: rtl/rv32i_pkg.sv
// Shared fetch-path types: buffered instruction entry and fetch FSM states.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_BOOT,
        FS_FETCH,
        FS_FLUSH
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it and voids same-cycle push/pop.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: owns the PC, issues credit-limited imem requests, buffers words,
// and on a taken branch redirects, flushes and discards every old-path response.
module fetch_redirect_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FBUF_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(FBUF_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [OW-1:0] outst_q, outst_d, kill_q, kill_d;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, req_fire, redirect, rsp_keep, push, pop;
    logic [31:0]   target;
    logic          unused_tgt_bits;
    fetch_entry_t  head, push_entry;

    assign redirect        = br_valid && br_taken;
    assign target          = {br_target[31:2], 2'b00};
    assign unused_tgt_bits = ^br_target[1:0];

    // Credit rule: a request only issues if its response is guaranteed a buffer slot.
    assign imem_req_valid = (state_q != FS_BOOT)
                         && (32'(outst_q) + 32'(fifo_count) < 32'(FBUF_DEPTH))
                         && (32'(outst_q) < 32'(MAX_OUTSTANDING));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FS_BOOT;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            kill_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            kill_q   <= kill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q + OW'(req_fire) - OW'(imem_rsp_valid);
        kill_d   = kill_q;
        rsp_keep = 1'b0;

        if (imem_rsp_valid) begin
            if (kill_q != '0) begin
                kill_d = kill_q - OW'(1);
            end else begin
                rsp_keep = 1'b1;
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
        end
        if (req_fire) pc_d = pc_q + 32'd4;

        case (state_q)
            FS_BOOT:  state_d = FS_FETCH;
            FS_FETCH: state_d = FS_FETCH;
            FS_FLUSH: if (kill_d == '0) state_d = FS_FETCH;
            default:  state_d = FS_BOOT;
        endcase

        // Everything still outstanding after this edge belongs to the old path.
        if (redirect) begin
            pc_d     = target;
            rsp_pc_d = target;
            kill_d   = outst_d;
            state_d  = (outst_d != '0) ? FS_FLUSH : FS_FETCH;
        end
    end

    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign push       = rsp_keep && !redirect;
    assign pop        = !fifo_empty && if_ready;

    fetch_fifo #(.DEPTH(FBUF_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign if_valid = !fifo_empty;
    assign if_instr = fifo_empty ? 32'h0 : head.instr;
    assign if_pc    = fifo_empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench: vector table, directed redirect/reset corners, random run vs path-epoch model.
module tb_fetch_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        br_valid, br_taken, if_valid, if_ready;
    logic [31:0] br_target, if_instr, if_pc;

    always #5 clk = ~clk;

    fetch_redirect_unit #(.RESET_PC(RESET_PC), .FBUF_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
    );

    // Model: each accepted request is tagged with the path epoch it was issued on;
    // only words of the current epoch reach decode.
    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } word_t;
    typedef struct { logic rdy; logic ifr; logic exp_rv; logic [31:0] exp_addr;
                     logic exp_ifv; logic [31:0] exp_pc; } vec_t;

    req_t        memq[$];
    word_t       expq[$];
    logic [31:0] model_pc;
    int          epoch = 0, cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    int          errors = 0, checks = 0;
    vec_t        tv[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic exp_req_valid();
        return (memq.size() + expq.size() < DEPTH) && (memq.size() < MAXO);
    endfunction

    function automatic logic rsp_due();
        return (memq.size() != 0) && (memq[0].due == cyc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Called just after a rising edge: check outputs, drive one cycle, advance the model.
    task automatic cycle(input logic rdy, input logic ifr, input logic bv, input logic bt,
                         input logic [31:0] tgt);
        logic ev, fire, rv, keep;
        req_t r, n;
        word_t w;
        int lat;
        ev = exp_req_valid();
        chk("req_valid", 32'(imem_req_valid), 32'(ev));
        chk("if_valid", 32'(if_valid), 32'(expq.size() != 0));
        if (expq.size() != 0) begin
            chk("if_pc", if_pc, expq[0].pc);
            chk("if_instr", if_instr, expq[0].instr);
        end
        if (expq.size() > DEPTH) fail_now("fbuf_overflow");
        fire = ev && rdy;
        if (fire) chk("req_addr", imem_req_addr, model_pc);
        rv = rsp_due();
        imem_req_ready = rdy;
        if_ready       = ifr;
        br_valid       = bv;
        br_taken       = bt;
        br_target      = tgt;
        imem_rsp_valid = rv;
        keep           = 1'b0;
        if (rv) begin
            r = memq.pop_front();
            imem_rsp_data = mem_word(r.addr);
            keep = (r.epoch == epoch) && !(bv && bt);
            w.pc = r.addr;
            w.instr = mem_word(r.addr);
        end else begin
            imem_rsp_data = $urandom();
        end
        if (ifr && expq.size() != 0) void'(expq.pop_front());
        if (keep) expq.push_back(w);
        if (fire) begin
            lat = $urandom_range(lat_max, lat_min);
            n.addr = model_pc;
            n.epoch = epoch;
            n.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = n.due;
            memq.push_back(n);
            model_pc = model_pc + 32'd4;
        end
        if (bv && bt) begin
            expq.delete();
            epoch++;
            model_pc = {tgt[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        br_valid       = 1'b0;
        br_taken       = 1'b0;
        br_target      = 32'h0;
        if_ready       = 1'b0;
    endtask

    // Asynchronous reset check, then release and check the BOOT cycle; returns in FETCH.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        memq.delete();
        expq.delete();
        model_pc = RESET_PC;
        epoch++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("boot_req_valid", 32'(imem_req_valid), 32'h0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_head(input string name, input logic [31:0] exp_pc);
        for (int i = 0; i < 20; i++) begin
            if (if_valid) break;
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        if (!if_valid) fail_now(name);
        else chk(name, if_pc, exp_pc);
    endtask

    task automatic build_outstanding();
        for (int i = 0; i < 20 && memq.size() < MAXO; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        if (memq.size() < MAXO) fail_now("setup_outstanding");
    endtask

    initial begin
        logic found;
        tv[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tv[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tv[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tv[3] = '{1'b1, 1'b1, 1'b1, 32'h0c, 1'b1, 32'h04};
        tv[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tv[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0c};
        tv[6] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tv[7] = '{1'b1, 1'b1, 1'b1, 32'h1c, 1'b1, 32'h14};

        do_reset();

        // 1: streaming with 1-cycle memory
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) begin
            chk("tv_req_valid", 32'(imem_req_valid), 32'(tv[i].exp_rv));
            if (tv[i].exp_rv) chk("tv_req_addr", imem_req_addr, tv[i].exp_addr);
            chk("tv_if_valid", 32'(if_valid), 32'(tv[i].exp_ifv));
            if (tv[i].exp_ifv) begin
                chk("tv_if_pc", if_pc, tv[i].exp_pc);
                chk("tv_if_instr", if_instr, mem_word(tv[i].exp_pc));
            end
            cycle(tv[i].rdy, tv[i].ifr, 1'b0, 1'b0, 32'h0);
        end

        // 2: decode stall fills the credit window, then drains without loss
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
        chk("stall_if_valid", 32'(if_valid), 32'h1);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // 3: taken branch with two requests in flight
        lat_min = 3; lat_max = 3;
        build_outstanding();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
        wait_head("redir_head_pc", 32'h100);

        // 4: redirect in a cycle with both a request fire and a response
        lat_min = 1; lat_max = 1;
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (exp_req_valid() && rsp_due()) begin
                cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h240);
                found = 1'b1;
                break;
            end
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        if (!found) fail_now("fire_rsp_setup");
        wait_head("same_cycle_head_pc", 32'h240);

        // 5: not-taken and taken-without-valid are ignored; unaligned target aligns
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h5000);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h6000);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h203);
        chk("align_req_addr", imem_req_addr, 32'h200);
        wait_head("align_head_pc", 32'h200);

        // 6: reset while flushing
        lat_min = 3; lat_max = 3;
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        build_outstanding();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
        do_reset();
        lat_min = 1; lat_max = 1;
        wait_head("restart_head_pc", RESET_PC);

        // Random traffic with variable latency, stalls and redirects
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)), $urandom());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
